// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank -- small register file sitting on a shared tri-state CPU bus.
//
// A register is written from the bus (LOAD) or modified in place (INC, DEC,
// SHL), and the zero/carry flags are updated from the result of every
// executed write. Register 0 and register 1 are exposed continuously as ALU
// taps. One register at a time can be driven onto the bus.
//
// Parameters:
//   WIDTH  data width of every register, tap and the bus (must be >= 2)
//   NREGS  register count, power of two, >= 2
//   SELW   derived select width, $clog2(NREGS); not user-settable
//
// Ports:
//   clk       single clock, all state changes on its rising edge
//   clr       synchronous active-high reset of registers and flags
//   bus       shared tri-state bus: sampled for LOAD, driven for reads
//   wsel      index of the register written
//   rsel      index of the register driven onto the bus
//   wr_n      active-low write enable
//   oe_n      active-low bus output enable
//   op        write operation: 00 LOAD, 01 INC, 10 DEC, 11 SHL
//   tap_a     continuous copy of register 0
//   tap_b     continuous copy of register 1
//   zf        registered zero flag of the last executed write
//   cf        registered carry/borrow flag of the last executed write
//   conflict  one-cycle pulse after a suppressed self-driven LOAD
// -----------------------------------------------------------------------------
module reg_bank #(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int SELW  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  inout  wire  [WIDTH-1:0] bus,
  input  logic [SELW-1:0]  wsel,
  input  logic [SELW-1:0]  rsel,
  input  logic             wr_n,
  input  logic             oe_n,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] tap_a,
  output logic [WIDTH-1:0] tap_b,
  output logic             zf,
  output logic             cf,
  output logic             conflict
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_SHL  = 2'b11;

  logic [WIDTH-1:0] regs_reg [NREGS];
  logic             zf_reg;
  logic             cf_reg;
  logic             conflict_reg;

  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] result_next;
  logic             carry_next;
  logic             is_conflict;
  logic             do_write;
  logic [NREGS-1:0] we;

  // Result and carry for the selected operation on the addressed register.
  always_comb begin
    cur_val     = regs_reg[wsel];
    result_next = bus;
    carry_next  = 1'b0;
    case (op)
      OP_INC: begin
        {carry_next, result_next} = {1'b0, cur_val} + (WIDTH+1)'(1);
      end
      OP_DEC: begin
        result_next = cur_val - WIDTH'(1);
        carry_next  = (cur_val == '0);  // borrow only when wrapping from 0
      end
      OP_SHL: begin
        result_next = {cur_val[WIDTH-2:0], 1'b0};
        carry_next  = cur_val[WIDTH-1];
      end
      default: begin
        result_next = bus;
        carry_next  = 1'b0;
      end
    endcase
  end

  // A LOAD while we are driving the bus ourselves would just read back our
  // own output; it is refused and reported instead. INC/DEC/SHL never use
  // the bus, so they run normally with the output enabled.
  always_comb begin
    is_conflict = !wr_n && !oe_n && (op == OP_LOAD);
    do_write    = !wr_n && !is_conflict;
  end

  // Per-register write enables decoded from wsel.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_we
      assign we[gi] = do_write && (wsel == SELW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
      zf_reg       <= 1'b0;
      cf_reg       <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we[i]) begin
          regs_reg[i] <= result_next;
        end
      end
      if (do_write) begin
        zf_reg <= (result_next == '0);
        cf_reg <= carry_next;
      end
      conflict_reg <= is_conflict;
    end
  end

  // Bus drive is purely combinational and independent of clr.
  assign bus      = oe_n ? {WIDTH{1'bz}} : regs_reg[rsel];
  assign tap_a    = regs_reg[0];
  assign tap_b    = regs_reg[1];
  assign zf       = zf_reg;
  assign cf       = cf_reg;
  assign conflict = conflict_reg;

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] INC  = 2'b01;
  localparam logic [1:0] DEC  = 2'b10;
  localparam logic [1:0] SHL  = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default instance: WIDTH=8, NREGS=4 ----------------
  logic       clr, wr_n, oe_n;
  logic [1:0] wsel, rsel, op;
  logic [7:0] tap_a, tap_b, bus_drv;
  logic       zf, cf, conflict, bus_en;
  wire  [7:0] bus;
  assign bus = bus_en ? bus_drv : 8'hzz;

  reg_bank dut (
    .clk(clk), .clr(clr), .bus(bus), .wsel(wsel), .rsel(rsel),
    .wr_n(wr_n), .oe_n(oe_n), .op(op), .tap_a(tap_a), .tap_b(tap_b),
    .zf(zf), .cf(cf), .conflict(conflict)
  );

  // ---------------- WIDTH=4, NREGS=8 ----------------
  logic       clr4, wr_n4, oe_n4;
  logic [2:0] wsel4, rsel4;
  logic [1:0] op4;
  logic [3:0] tap_a4, tap_b4, bus4_drv;
  logic       zf4, cf4, conflict4, bus4_en;
  wire  [3:0] bus4;
  assign bus4 = bus4_en ? bus4_drv : 4'hz;

  reg_bank #(.WIDTH(4), .NREGS(8)) dut4 (
    .clk(clk), .clr(clr4), .bus(bus4), .wsel(wsel4), .rsel(rsel4),
    .wr_n(wr_n4), .oe_n(oe_n4), .op(op4), .tap_a(tap_a4), .tap_b(tap_b4),
    .zf(zf4), .cf(cf4), .conflict(conflict4)
  );

  // ---------------- WIDTH=16, NREGS=4 ----------------
  logic        clr16, wr_n16, oe_n16;
  logic [1:0]  wsel16, rsel16, op16;
  logic [15:0] tap_a16, tap_b16, bus16_drv;
  logic        zf16, cf16, conflict16, bus16_en;
  wire  [15:0] bus16;
  assign bus16 = bus16_en ? bus16_drv : 16'hzzzz;

  reg_bank #(.WIDTH(16), .NREGS(4)) dut16 (
    .clk(clk), .clr(clr16), .bus(bus16), .wsel(wsel16), .rsel(rsel16),
    .wr_n(wr_n16), .oe_n(oe_n16), .op(op16), .tap_a(tap_a16), .tap_b(tap_b16),
    .zf(zf16), .cf(cf16), .conflict(conflict16)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic push(input string tag, input logic [15:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [15:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed 0x%0h with no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
      end
      $display("check %-14s observed 0x%0h expected 0x%0h", e.tag, obs, e.exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] sel, input logic [7:0] val);
    wsel = sel; op = LOAD; oe_n = 1'b1;
    bus_drv = val; bus_en = 1'b1; wr_n = 1'b0;
    cycle();
    wr_n = 1'b1; bus_en = 1'b0;
  endtask

  // Arithmetic write with junk on the bus, which must be ignored.
  task automatic arith(input logic [1:0] sel, input logic [1:0] o);
    wsel = sel; op = o; oe_n = 1'b1;
    bus_drv = 8'h5A; bus_en = 1'b1; wr_n = 1'b0;
    cycle();
    wr_n = 1'b1; bus_en = 1'b0;
  endtask

  initial begin
    clr = 1'b1; wr_n = 1'b1; oe_n = 1'b1; op = LOAD; wsel = '0; rsel = '0;
    bus_drv = '0; bus_en = 1'b0;
    clr4 = 1'b1; wr_n4 = 1'b1; oe_n4 = 1'b1; op4 = LOAD; wsel4 = '0; rsel4 = '0;
    bus4_drv = '0; bus4_en = 1'b0;
    clr16 = 1'b1; wr_n16 = 1'b1; oe_n16 = 1'b1; op16 = LOAD; wsel16 = '0;
    rsel16 = '0; bus16_drv = '0; bus16_en = 1'b0;

    // Reset state
    push("rst_tap_a", 16'h00); push("rst_tap_b", 16'h00);
    push("rst_zf", 16'h0); push("rst_cf", 16'h0); push("rst_conflict", 16'h0);
    cycle();
    clr = 1'b0; clr4 = 1'b0; clr16 = 1'b0;
    chk(16'(tap_a)); chk(16'(tap_b)); chk(16'(zf)); chk(16'(cf)); chk(16'(conflict));

    oe_n = 1'b0; rsel = 2'd2; #1;
    push("rst_reg2_bus", 16'h00); chk(16'(bus));
    oe_n = 1'b1;

    // LOAD reg2=0xAA, read it back, then release the bus
    push("load_zf", 16'h0); push("load_cf", 16'h0);
    load(2'd2, 8'hAA);
    chk(16'(zf)); chk(16'(cf));
    oe_n = 1'b0; rsel = 2'd2; #1;
    push("read_reg2", 16'hAA); chk(16'(bus));
    oe_n = 1'b1; #1;
    push("bus_hiz", 16'h1); chk(16'(bus === 8'hzz));

    // INC wrap, then INC again
    load(2'd0, 8'hFF);
    push("inc_wrap_tap_a", 16'h00); push("inc_wrap_zf", 16'h1); push("inc_wrap_cf", 16'h1);
    arith(2'd0, INC);
    chk(16'(tap_a)); chk(16'(zf)); chk(16'(cf));
    push("inc_tap_a", 16'h01); push("inc_zf", 16'h0); push("inc_cf", 16'h0);
    arith(2'd0, INC);
    chk(16'(tap_a)); chk(16'(zf)); chk(16'(cf));

    // DEC borrow
    load(2'd1, 8'h00);
    push("dec_tap_b", 16'hFF); push("dec_cf", 16'h1); push("dec_zf", 16'h0);
    arith(2'd1, DEC);
    chk(16'(tap_b)); chk(16'(cf)); chk(16'(zf));

    // SHL with bus enabled on the same register: pre-edge then post-edge value
    load(2'd1, 8'h81);
    oe_n = 1'b0; rsel = 2'd1; wsel = 2'd1; op = SHL; wr_n = 1'b0; #1;
    push("shl_bus_pre", 16'h81); chk(16'(bus));
    push("shl_tap_b", 16'h02); push("shl_cf", 16'h1); push("shl_zf", 16'h0);
    push("shl_bus_post", 16'h02); push("shl_no_conflict", 16'h0);
    cycle();
    wr_n = 1'b1;
    chk(16'(tap_b)); chk(16'(cf)); chk(16'(zf)); chk(16'(bus)); chk(16'(conflict));
    oe_n = 1'b1;

    // Conflict: self-driven LOAD is refused, flags keep their set values
    load(2'd3, 8'h55);
    load(2'd0, 8'hFF);
    arith(2'd0, INC);
    wsel = 2'd3; rsel = 2'd3; op = LOAD; oe_n = 1'b0; wr_n = 1'b0;
    push("cfl_pulse", 16'h1); push("cfl_zf_hold", 16'h1);
    push("cfl_cf_hold", 16'h1); push("cfl_reg3", 16'h55);
    cycle();
    wr_n = 1'b1;
    chk(16'(conflict)); chk(16'(zf)); chk(16'(cf)); chk(16'(bus));
    push("cfl_end", 16'h0);
    cycle();
    chk(16'(conflict));
    push("cfl_reg3_after", 16'h55); chk(16'(bus));
    oe_n = 1'b1;

    // Reset wins over a simultaneous INC
    load(2'd0, 8'h10);
    load(2'd2, 8'hFF);
    arith(2'd2, INC);
    clr = 1'b1; wsel = 2'd0; op = INC; wr_n = 1'b0;
    push("rstop_tap_a", 16'h00); push("rstop_zf", 16'h0);
    push("rstop_cf", 16'h0); push("rstop_conflict", 16'h0);
    cycle();
    clr = 1'b0; wr_n = 1'b1;
    chk(16'(tap_a)); chk(16'(zf)); chk(16'(cf)); chk(16'(conflict));
    oe_n = 1'b0; rsel = 2'd3; #1;
    push("rstop_reg3", 16'h00); chk(16'(bus));
    oe_n = 1'b1;

    // Hold with wr_n=1 and junk on the other inputs
    load(2'd1, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      op = 2'($urandom_range(0, 3)); wsel = 2'd1;
      bus_drv = 8'($urandom); bus_en = 1'b1;
      push("hold_tap_b", 16'h3C); push("hold_zf", 16'h0); push("hold_cf", 16'h0);
      cycle();
      chk(16'(tap_b)); chk(16'(zf)); chk(16'(cf));
    end
    bus_en = 1'b0;

    // WIDTH=4, NREGS=8: INC wraps reg7
    wsel4 = 3'd7; op4 = LOAD; bus4_drv = 4'hF; bus4_en = 1'b1; wr_n4 = 1'b0;
    cycle();
    op4 = INC; bus4_drv = 4'h3;
    push("w4_cf", 16'h1); push("w4_zf", 16'h1); push("w4_tap_a", 16'h0);
    cycle();
    wr_n4 = 1'b1; bus4_en = 1'b0;
    chk(16'(cf4)); chk(16'(zf4)); chk(16'(tap_a4));
    oe_n4 = 1'b0; rsel4 = 3'd7; #1;
    push("w4_reg7", 16'h0); chk(16'(bus4));
    oe_n4 = 1'b1;

    // WIDTH=16: SHL of 0x8000
    wsel16 = 2'd0; op16 = LOAD; bus16_drv = 16'h8000; bus16_en = 1'b1; wr_n16 = 1'b0;
    cycle();
    op16 = SHL; bus16_drv = 16'h1234;
    push("w16_tap_a", 16'h0000); push("w16_zf", 16'h1); push("w16_cf", 16'h1);
    cycle();
    wr_n16 = 1'b1; bus16_en = 1'b0;
    chk(tap_a16); chk(16'(zf16)); chk(16'(cf16));

    if (sb_q.size() != 0) begin
      errors++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
